// File: rtl/clk_sel_pkg.sv
// Shared types and defaults for the clock-select controller and its activity monitors.
package clk_sel_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SETTLE = 1'b1
   } state_e;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_WIN_CYC     = 64;
   localparam int DEF_MIN_EDGES   = 4;
   localparam int DEF_SETTLE_CYC  = 32;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_sel_ctrl_act_mon.sv
// Per-clock activity monitor: synchronises a divide-by-2 toggle, counts its edges
// over one window and publishes an alive flag at each window boundary.
module clk_act_mon
   import clk_sel_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int MIN_EDGES   = DEF_MIN_EDGES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tgl_i,
   input  logic win_end_i,
   output logic ok_o
);

   localparam int CW = cnt_w(MIN_EDGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic [CW-1:0]          cnt_q;
   logic                   ok_q;
   logic                   edge_w;
   logic [CW:0]            sum_w;

   assign edge_w = sync_q[SYNC_STAGES-1] ^ dly_q;
   // The edge landing on the window's last cycle still counts for that window.
   assign sum_w  = {1'b0, cnt_q} + (CW+1)'(edge_w);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         cnt_q  <= '0;
         ok_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
         dly_q  <= sync_q[SYNC_STAGES-1];
         if (win_end_i) begin
            ok_q  <= (sum_w >= (CW+1)'(MIN_EDGES));
            cnt_q <= '0;
         end else if (edge_w && (cnt_q < CW'(MIN_EDGES))) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign ok_o = ok_q;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-select initiator: judges clock liveness, arbitrates software requests
// against automatic failover and holds completion until the switch has settled.
module clk_sel_ctrl
   import clk_sel_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int WIN_CYC     = DEF_WIN_CYC,
   parameter int MIN_EDGES   = DEF_MIN_EDGES,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic clk1_tgl,
   input  logic clk2_tgl,
   input  logic failover_en,
   input  logic req_valid,
   input  logic req_sel_clk1,
   output logic req_ready,
   output logic sel_clk1,
   output logic busy,
   output logic done,
   output logic err,
   output logic fail_evt,
   output logic clk1_ok,
   output logic clk2_ok
);

   localparam int WW = cnt_w(WIN_CYC);
   localparam int SW = cnt_w(SETTLE_CYC);

   // Handshake: a request transfers on any cycle where req_valid && req_ready;
   // req_ready never depends on req_valid, and the requester holds req_sel_clk1
   // stable while req_valid is high.

   logic [WW-1:0] win_q;
   logic          win_end_w;
   state_e        state_q, state_d;
   logic          sel_q, sel_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          fail_q, fail_d;
   logic          cur_ok_w, oth_ok_w, tgt_ok_w, fo_cond_w, accept_w;

   assign win_end_w = (win_q == WW'(WIN_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) win_q <= '0;
      else     win_q <= win_end_w ? '0 : win_q + WW'(1);
   end

   clk_act_mon #(.SYNC_STAGES(SYNC_STAGES), .MIN_EDGES(MIN_EDGES)) u_mon1 (
      .clk_i(clk), .rst_i(rst), .tgl_i(clk1_tgl), .win_end_i(win_end_w), .ok_o(clk1_ok)
   );

   clk_act_mon #(.SYNC_STAGES(SYNC_STAGES), .MIN_EDGES(MIN_EDGES)) u_mon2 (
      .clk_i(clk), .rst_i(rst), .tgl_i(clk2_tgl), .win_end_i(win_end_w), .ok_o(clk2_ok)
   );

   assign cur_ok_w  = sel_q ? clk1_ok : clk2_ok;
   assign oth_ok_w  = sel_q ? clk2_ok : clk1_ok;
   assign tgt_ok_w  = req_sel_clk1 ? clk1_ok : clk2_ok;
   assign fo_cond_w = failover_en && !cur_ok_w && oth_ok_w;
   assign req_ready = (state_q == ST_IDLE) && !fo_cond_w;
   assign accept_w  = req_valid && req_ready;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      settle_d = settle_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      fail_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fo_cond_w) begin
               sel_d    = !sel_q;
               fail_d   = 1'b1;
               settle_d = SW'(SETTLE_CYC - 1);
               state_d  = ST_SETTLE;
            end else if (accept_w) begin
               if (req_sel_clk1 == sel_q) begin
                  done_d = 1'b1;
               end else if (tgt_ok_w) begin
                  sel_d    = req_sel_clk1;
                  settle_d = SW'(SETTLE_CYC - 1);
                  state_d  = ST_SETTLE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            if (settle_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b1;
         settle_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         settle_q <= settle_d;
         done_q   <= done_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
      end
   end

   assign sel_clk1 = sel_q;
   assign busy     = (state_q == ST_SETTLE);
   assign done     = done_q;
   assign err      = err_q;
   assign fail_evt = fail_q;

endmodule

// File: doc/clk_sel_ctrl.md
# clk_sel_ctrl

Initiator side of the glitch-free clock switch: runs on an always-on reference clock, judges whether each candidate clock is alive, and produces the `sel_clk1` select that the switch consumes. It accepts software switch requests through a valid/ready handshake and rejects requests to a dead clock. It optionally fails over automatically when the active clock stops. It holds off completion until the switch's internal synchroniser chains have settled.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for each toggle input (≥2).
- `WIN_CYC`, 64: activity-check window length in `clk` cycles (≥8).
- `MIN_EDGES`, 4: toggle edges required per window to declare a clock alive (1..WIN_CYC/4).
- `SETTLE_CYC`, 32: `clk` cycles between a `sel_clk1` change and `done` (≥8; covers the switch's 3+2-stage handover at the slowest source clock).

Ports (reset values of outputs in brackets):
- `clk` in 1: reference clock, always running.
- `rst` in 1: synchronous, active-high reset.
- `clk1_tgl` in 1: toggles on every `clk1` rising edge (divide-by-2 flop in the `clk1` domain); asynchronous to `clk`.
- `clk2_tgl` in 1: same, for `clk2`.
- `failover_en` in 1: enables automatic failover.
- `req_valid` in 1: switch request valid.
- `req_sel_clk1` in 1: requested target (1 = `clk1`, 0 = `clk2`).
- `req_ready` out 1 [1]: request accepted when `req_valid && req_ready`.
- `sel_clk1` out 1 [1]: select to the clock switch.
- `busy` out 1 [0]: a switch is settling.
- `done` out 1 [0]: one-cycle pulse when a request or failover completes.
- `err` out 1 [0]: one-cycle pulse when a request is rejected.
- `fail_evt` out 1 [0]: one-cycle pulse at the start of an automatic failover.
- `clk1_ok` out 1 [0]: `clk1` judged alive in the last completed window.
- `clk2_ok` out 1 [0]: same, for `clk2`.

## Operation
- **Activity monitor, per clock.**
  - The toggle input passes through `SYNC_STAGES` flops plus one delay flop; an XOR of the two produces an edge pulse.
  - A saturating edge counter is `$clog2(MIN_EDGES+1)` bits wide and saturates at `MIN_EDGES`.
  - A shared window counter, `$clog2(WIN_CYC)` bits, runs 0..WIN_CYC-1 and wraps.
  - At count WIN_CYC-1: `clkN_ok <= (edges + edge_this_cycle >= MIN_EDGES)`, and the edge counter clears to 0.
  - `clkN_ok` changes only at window boundaries.
  - Source clocks must satisfy f_clkN ≤ f_clk for the toggle to be sampled correctly.
- **FSM states:** IDLE, SETTLE.
  - **IDLE:** `req_ready = !fo_cond`, where `fo_cond = failover_en && !cur_ok && oth_ok`. `cur_ok` is the ok flag of the clock `sel_clk1` points at; `oth_ok` is the other flag.
  - `fo_cond` in IDLE: flip `sel_clk1`, pulse `fail_evt`, load the settle counter, go to SETTLE. Failover takes priority over a simultaneous request, which is not accepted that cycle.
  - Accepted request with target == `sel_clk1`: pulse `done` next cycle, stay in IDLE.
  - Accepted request with target ≠ `sel_clk1` and target ok: set `sel_clk1 <= req_sel_clk1`, go to SETTLE.
  - Accepted request with target ≠ `sel_clk1` and target not ok: pulse `err` next cycle, `sel_clk1` unchanged.
  - **SETTLE:** `busy = 1`, `req_ready = 0`. The settle counter counts SETTLE_CYC cycles; on expiry, pulse `done` and return to IDLE. Ok-flag changes during SETTLE are ignored until IDLE.
- Both clocks dead: no failover, and all requests to change are rejected with `err`.
- Reset at any time, including mid-SETTLE: FSM to IDLE, `sel_clk1 = 1`, all counters 0, ok flags 0, all pulses 0.

## Timing
- Toggle transition to edge pulse: SYNC_STAGES+1 `clk` cycles.
- Accept at cycle T: `sel_clk1` changes at T+1, `busy` is high from T+1 through T+SETTLE_CYC, and `done` is high at T+SETTLE_CYC+1 with `busy` low.
- Same-target or reject: `done` or `err` at T+1; `req_ready` stays high.
- Failover detected at cycle T: `sel_clk1` flips and `fail_evt` pulses at T+1; `done` pulses at T+SETTLE_CYC+1.
- After reset: first valid ok flags appear at the end of the first window (WIN_CYC cycles), so requests to `clk2` before then get `err`.

## Structure
- Package `clk_sel_pkg` holds the FSM state enum (IDLE, SETTLE) and the counter-width localparams.
- Sub-module `clk_act_mon` contains the synchroniser, edge detect, saturating counter and ok flag. It is instantiated twice and takes the shared window-end strobe as an input.
- The top level holds the window counter, FSM, settle counter and handshake.

## Test plan
- **Reset and idle clocks:** both clocks toggling at f_clk/4, defaults. Expect `clk1_ok = clk2_ok = 1` after the first window and `sel_clk1 = 1`.
- **Valid switch:** request `req_sel_clk1 = 0` accepted at T. Expect `sel_clk1 = 0` at T+1, `busy` over T+1..T+32, `done` at T+33.
- **Dead target:** stop `clk2_tgl`, wait 2 windows, request `clk2`. Expect `err` at T+1 and `sel_clk1` stays 1.
- **Failover and priority:** `failover_en = 1`, on `clk1`, stop `clk1_tgl`. At the next window end expect `fail_evt` and `sel_clk1 = 0`. A simultaneous `req_valid` sees `req_ready = 0`.
- **Reset mid-SETTLE:** assert `rst` 10 cycles into SETTLE. Expect `sel_clk1 = 1`, `busy = 0`, no `done`, ok flags 0.
- **Same-target request:** request `clk1` while on `clk1`. Expect `done` at T+1 and no `busy`.
